// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and sizes for the register-file write arbiter.
//   DATA_W    register width
//   ADDR_W    register address width
//   NUM_REGS  number of architectural registers (2**ADDR_W)
//   wr_req_t  one write request {addr, data}
//   arb_state_t  arbiter priority state {WB_PRI, LS_PRI}
//   onehot()  register address -> one-hot register mask
// ---------------------------------------------------------------------------
package rf_arb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        WB_PRI = 1'b0,
        LS_PRI = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// ---------------------------------------------------------------------------
// rf_arb_fifo
// QDEPTH-entry synchronous FIFO of wr_req_t holding secondary-path writes.
// Entry 0 is always the head; a pop shifts every entry down by one, so the
// occupied slots are always 0..count-1 and never reorder.
// Ports:
//   clk, reset   clock / synchronous active-high reset (empties the FIFO)
//   push, din    enqueue din when push && !full
//   pop          dequeue head when pop && !empty
//   full, empty  occupancy flags
//   head         current head entry (valid when !empty)
//   ent_valid    per-slot occupied flag
//   ent_addr     per-slot target register address
// ---------------------------------------------------------------------------
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  wr_req_t                       din,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output wr_req_t                       head,
    output logic [QDEPTH-1:0]             ent_valid,
    output logic [QDEPTH-1:0][ADDR_W-1:0] ent_addr
);

    localparam int CW = $clog2(QDEPTH + 1);

    wr_req_t        mem   [QDEPTH];
    wr_req_t        mem_n [QDEPTH];
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_n;
    logic [CW-1:0]  wr_idx;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == CW'(QDEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[0];

    // With a simultaneous pop the surviving entries slide down one slot,
    // so the new entry lands one slot lower than the current count.
    assign wr_idx  = count - CW'(pop_ok);
    assign count_n = count + CW'(push_ok) - CW'(pop_ok);

    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            mem_n[i] = mem[i];
        end
        if (pop_ok) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                mem_n[i] = mem[i+1];
            end
        end
        if (push_ok) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    mem_n[i] = din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_n;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= mem_n[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            ent_valid[i] = (CW'(i) < count);
            ent_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Arbitrates the single RF write port between the writeback stage (primary)
// and a queued long-latency return path (secondary). A starvation guard
// forces the queue head through after it has waited MAX_WAIT cycles.
// Optional feature macro: RFARB_FWD_EN (write-port forwarding lookups).
// Ports:
//   clk, reset                 clock / synchronous active-high reset
//   wb_valid/ready/addr/data   primary write request (valid/ready)
//   ls_valid/ready/addr/data   secondary write request, enqueued on handshake
//   rf_write/rf_addr3/rf_data3 registered RF write port
//   busy                       per-register pending-write mask (comb)
//   rd_addr1/2                 forwarding lookup addresses
//   fwd_hit1/2, fwd_data1/2    forwarding results (0 without RFARB_FWD_EN)
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; ready never depends on valid of the same channel.
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int QDEPTH   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                ls_valid,
    output logic                ls_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_data,
    output logic                rf_write,
    output logic [ADDR_W-1:0]   rf_addr3,
    output logic [DATA_W-1:0]   rf_data3,
    output logic [NUM_REGS-1:0] busy,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic                fwd_hit1,
    output logic                fwd_hit2,
    output logic [DATA_W-1:0]   fwd_data1,
    output logic [DATA_W-1:0]   fwd_data2
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    arb_state_t                    state;
    arb_state_t                    state_n;
    logic [WW-1:0]                 wait_cnt;
    logic [WW-1:0]                 wait_n;
    logic                          push;
    logic                          pop;
    logic                          grant_wb;
    logic                          q_full;
    logic                          q_empty;
    wr_req_t                       q_head;
    wr_req_t                       ls_req;
    logic [QDEPTH-1:0]             ent_valid;
    logic [QDEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [NUM_REGS-1:0]           q_busy;

    assign ls_req.addr = ls_addr;
    assign ls_req.data = ls_data;
    assign ls_ready    = !reset && !q_full;
    assign push        = ls_valid && ls_ready;

    rf_arb_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .din       (ls_req),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WB_PRI;
        end else begin
            state <= state_n;
        end
    end

    // FSM: next state. LS_PRI lasts exactly one cycle.
    always_comb begin
        state_n = state;
        case (state)
            WB_PRI:  if (wait_n == WW'(MAX_WAIT)) state_n = LS_PRI;
            LS_PRI:  state_n = WB_PRI;
            default: state_n = WB_PRI;
        endcase
    end

    // FSM: outputs / grant
    always_comb begin
        wb_ready = 1'b0;
        grant_wb = 1'b0;
        pop      = 1'b0;
        if (!reset) begin
            case (state)
                WB_PRI: begin
                    wb_ready = 1'b1;
                    if (wb_valid) begin
                        grant_wb = 1'b1;
                    end else if (!q_empty) begin
                        pop = 1'b1;
                    end
                end
                LS_PRI: begin
                    pop = !q_empty;
                end
                default: begin
                    wb_ready = 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts edges where a valid head is passed over.
    always_comb begin
        if (q_empty || pop) begin
            wait_n = '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_n = wait_cnt + WW'(1);
        end else begin
            wait_n = wait_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_n;
        end
    end

    // Issue register: address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write <= 1'b0;
            rf_addr3 <= '0;
            rf_data3 <= '0;
        end else begin
            rf_write <= grant_wb || pop;
            if (grant_wb) begin
                rf_addr3 <= wb_addr;
                rf_data3 <= wb_data;
            end else if (pop) begin
                rf_addr3 <= q_head.addr;
                rf_data3 <= q_head.data;
            end
        end
    end

    always_comb begin
        q_busy = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (ent_valid[i]) begin
                q_busy = q_busy | onehot(ent_addr[i]);
            end
        end
    end

    assign busy = reset ? '0 : (q_busy | (rf_write ? onehot(rf_addr3) : '0));

`ifdef RFARB_FWD_EN
    // The RF only reflects a write the cycle after rf_write, so readers
    // of that register take the value from the issue register meanwhile.
    assign fwd_hit1  = rf_write && (rf_addr3 == rd_addr1);
    assign fwd_hit2  = rf_write && (rf_addr3 == rd_addr2);
    assign fwd_data1 = rf_data3;
    assign fwd_data2 = rf_data3;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr1, rd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    localparam int QD = 2;
    localparam int MW = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ls_valid;
    logic        ls_ready;
    logic [1:0]  ls_addr;
    logic [15:0] ls_data;
    logic        rf_write;
    logic [1:0]  rf_addr3;
    logic [15:0] rf_data3;
    logic [3:0]  busy;
    logic [1:0]  rd_addr1;
    logic [1:0]  rd_addr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [15:0] fwd_data1;
    logic [15:0] fwd_data2;

    always #5 clk = ~clk;

    rf_write_arbiter #(.QDEPTH(QD), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ls_valid  (ls_valid),
        .ls_ready  (ls_ready),
        .ls_addr   (ls_addr),
        .ls_data   (ls_data),
        .rf_write  (rf_write),
        .rf_addr3  (rf_addr3),
        .rf_data3  (rf_data3),
        .busy      (busy),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_chk  = 0;
    int n_pass = 0;

    // queued secondary writes, {addr, data}
    logic [17:0] exp_q[$];
    int          m_wait   = 0;     // cycles the current head has been passed over
    bit          m_forced = 1'b0;  // head must go this cycle
    logic        m_wr     = 1'b0;
    logic [1:0]  m_addr   = '0;
    logic [15:0] m_data   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_busy();
        logic [3:0] b;
        b = '0;
        foreach (exp_q[i]) b[exp_q[i][17:16]] = 1'b1;
        if (m_wr) b[m_addr] = 1'b1;
        return b;
    endfunction

    // compare all outputs at the falling edge, then advance the model
    task automatic step();
        int         sz;
        bit         issued;
        bit         popped;
        logic [17:0] h;
        @(negedge clk);
        check("wb_ready", wb_ready, reset ? 1'b0 : !m_forced);
        check("ls_ready", ls_ready, reset ? 1'b0 : (exp_q.size() < QD));
        check("rf_write", rf_write, m_wr);
        check("rf_addr3", rf_addr3, m_addr);
        check("rf_data3", rf_data3, m_data);
        check("busy", busy, reset ? 4'b0 : model_busy());
`ifdef RFARB_FWD_EN
        check("fwd_hit1", fwd_hit1, m_wr && (m_addr == rd_addr1));
        check("fwd_hit2", fwd_hit2, m_wr && (m_addr == rd_addr2));
        check("fwd_data1", fwd_data1, m_data);
        check("fwd_data2", fwd_data2, m_data);
`else
        check("fwd_hit1", fwd_hit1, 1'b0);
        check("fwd_hit2", fwd_hit2, 1'b0);
        check("fwd_data1", fwd_data1, 16'h0);
        check("fwd_data2", fwd_data2, 16'h0);
`endif
        if (reset) begin
            exp_q.delete();
            m_wait = 0; m_forced = 1'b0;
            m_wr = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            sz = exp_q.size();
            issued = 1'b0; popped = 1'b0;
            if (m_forced || (!wb_valid && sz > 0)) begin
                if (sz > 0) begin
                    h = exp_q.pop_front();
                    popped = 1'b1; issued = 1'b1;
                    m_addr = h[17:16]; m_data = h[15:0];
                end
            end else if (wb_valid) begin
                issued = 1'b1;
                m_addr = wb_addr; m_data = wb_data;
            end
            if (ls_valid && sz < QD) exp_q.push_back({ls_addr, ls_data});
            if (sz == 0 || popped) m_wait = 0;
            else if (m_wait < MW) m_wait++;
            m_forced = !m_forced && (m_wait == MW);
            m_wr = issued;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        wb_valid = 1'b0; ls_valid = 1'b0;
    endtask

    task automatic drive_wb(input logic [1:0] a, input logic [15:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
    endtask

    // hold one secondary request until it is accepted (bounded)
    task automatic push_ls(input logic [1:0] a, input logic [15:0] d);
        bit acc;
        ls_valid = 1'b1; ls_addr = a; ls_data = d;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = ls_ready;
            step();
        end
        check("push_accepted", acc, 1'b1);
        ls_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int low_cnt;
        int low_idx;
        bit seen_beef;

        reset = 1'b1;
        wb_valid = 1'b1; wb_addr = 2'd0; wb_data = 16'h0;
        ls_valid = 1'b1; ls_addr = 2'd0; ls_data = 16'h0;
        rd_addr1 = 2'd0; rd_addr2 = 2'd0;
        @(posedge clk); #1;

        // 1: reset held with both requesters active
        repeat (2) step();
        reset = 1'b0;
        drive_idle();
        repeat (3) step();

        // 2: single primary write
        drive_wb(2'd2, 16'h1234);
        step();
        drive_idle();
        check("t2_write", rf_write, 1'b1);
        check("t2_addr", rf_addr3, 2'd2);
        check("t2_data", rf_data3, 16'h1234);
        check("t2_busy", busy, 4'b0100);
        step();
        check("t2_write_off", rf_write, 1'b0);

        // 3: starvation guard forces one secondary write through
        drive_wb(2'd0, 16'h0001);
        ls_valid = 1'b1; ls_addr = 2'd1; ls_data = 16'hBEEF;
        step();
        ls_valid = 1'b0;
        low_cnt = 0; low_idx = -1; seen_beef = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!wb_ready) begin
                low_cnt++;
                low_idx = i;
            end
            step();
            if (rf_write && rf_addr3 == 2'd1 && rf_data3 == 16'hBEEF) seen_beef = 1'b1;
        end
        check("t3_low_cycles", low_cnt, 1);
        check("t3_low_index", low_idx, 4);
        check("t3_beef_commit", seen_beef, 1'b1);

        // 4: queue fills, third push waits for a forced pop
        drive_wb(2'd0, 16'h0002);
        push_ls(2'd1, 16'hA000);
        push_ls(2'd2, 16'hA001);
        check("t4_full", ls_ready, 1'b0);
        push_ls(2'd3, 16'hA002);
        repeat (20) step();

        // 5: reset drops queued entries
        drive_wb(2'd0, 16'h0003);
        push_ls(2'd1, 16'hC000);
        push_ls(2'd2, 16'hC001);
        drive_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        check("t5_busy", busy, 4'b0);
        check("t5_write", rf_write, 1'b0);

        // 6: forwarding lookup on an issued write
        rd_addr1 = 2'd3; rd_addr2 = 2'd0;
        drive_wb(2'd3, 16'h5A5A);
        step();
        drive_idle();
`ifdef RFARB_FWD_EN
        check("t6_hit1", fwd_hit1, 1'b1);
        check("t6_data1", fwd_data1, 16'h5A5A);
`else
        check("t6_hit1", fwd_hit1, 1'b0);
        check("t6_data1", fwd_data1, 16'h0);
`endif
        check("t6_hit2", fwd_hit2, 1'b0);
        step();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            wb_valid = ($urandom_range(0, 9) < 6);
            wb_addr  = 2'($urandom_range(0, 3));
            wb_data  = 16'($urandom);
            ls_valid = ($urandom_range(0, 1) == 1);
            ls_addr  = 2'($urandom_range(0, 3));
            ls_data  = 16'($urandom);
            rd_addr1 = 2'($urandom_range(0, 3));
            rd_addr2 = 2'($urandom_range(0, 3));
            step();
        end
        reset = 1'b0;
        drive_idle();
        repeat (12) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
